// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEM-stage access controller between the EX/MEM register and the data
// memory port. Loads and stores run a req/ack transaction and stall the
// front of the pipeline. Non-memory instructions pass to MEM/WB in one cycle.
// Optional feature: define MEM_TIMEOUT_EN to bound the BUSY wait at
// TIMEOUT_CYCLES. On expiry the access completes with 32'hDEADBEEF and
// err_o is set (sticky).
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic [31:0] ALUres_i,
    input  logic [31:0] wrdata_i,
    input  logic [4:0]  WriteBackPath_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ALUres_o,
    output logic [31:0] rddata_o,
    output logic [4:0]  WriteBackPath_o,
    output logic        err_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Catch an out-of-range timeout setting at elaboration time
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_access_unit: TIMEOUT_CYCLES must be in 2..255");
    end

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        regwrite_q, regwrite_d;
    logic        memtoreg_q, memtoreg_d;
    logic [31:0] alures_q, alures_d;
    logic [31:0] rddata_q, rddata_d;
    logic [4:0]  wbpath_q, wbpath_d;

    logic        acc;
    logic        done;
    logic [31:0] rdata_eff;

    assign acc = MemRead_i | MemWrite_i;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       tmo;

    // Expiry fires on the TIMEOUT_CYCLES-th BUSY cycle; a real ack wins
    assign tmo       = (state_q == BUSY) && !mem_ack_i && (cnt_q == TMO_LAST);
    assign done      = mem_ack_i | tmo;
    assign rdata_eff = mem_ack_i ? mem_rdata_i : 32'hDEADBEEF;
    assign err_o     = err_q;
`else
    assign done      = mem_ack_i;
    assign rdata_eff = mem_rdata_i;
    assign err_o     = 1'b0;
`endif

    // Next-state, memory-port and MEM/WB update; stall is combinational
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        regwrite_d  = regwrite_q;
        memtoreg_d  = memtoreg_q;
        alures_d    = alures_q;
        rddata_d    = rddata_q;
        wbpath_d    = wbpath_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        stall_o     = 1'b0;

        case (state_q)
            IDLE: begin
                if (acc) begin
                    stall_o     = 1'b1;
                    state_d     = BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWrite_i;
                    mem_addr_d  = ALUres_i;
                    mem_wdata_d = wrdata_i;
                    regwrite_d  = 1'b0;
                    memtoreg_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = 8'd0;
`endif
                end else begin
                    regwrite_d  = RegWrite_i;
                    memtoreg_d  = MemtoReg_i;
                    alures_d    = ALUres_i;
                    wbpath_d    = WriteBackPath_i;
                    rddata_d    = 32'd0;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    regwrite_d  = RegWrite_i;
                    memtoreg_d  = MemtoReg_i;
                    alures_d    = ALUres_i;
                    wbpath_d    = WriteBackPath_i;
                    rddata_d    = mem_we_q ? 32'd0 : rdata_eff;
`ifdef MEM_TIMEOUT_EN
                    if (tmo) err_d = 1'b1;
`endif
                end else begin
                    stall_o     = 1'b1;
                    regwrite_d  = 1'b0;
                    memtoreg_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst_i) stall_o = 1'b0;
    end

    // State and output registers; reset drops mem_req_o without waiting for ack
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            alures_q    <= 32'd0;
            rddata_q    <= 32'd0;
            wbpath_q    <= 5'd0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
            alures_q    <= alures_d;
            rddata_q    <= rddata_d;
            wbpath_q    <= wbpath_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign mem_req_o       = mem_req_q;
    assign mem_we_o        = mem_we_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign RegWrite_o      = regwrite_q;
    assign MemtoReg_o      = memtoreg_q;
    assign ALUres_o        = alures_q;
    assign rddata_o        = rddata_q;
    assign WriteBackPath_o = wbpath_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemRead_i = 1'b0, MemWrite_i = 1'b0, RegWrite_i = 1'b0, MemtoReg_i = 1'b0;
    logic [31:0] ALUres_i = '0, wrdata_i = '0, mem_rdata_i = '0;
    logic [4:0]  WriteBackPath_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        mem_req_o, mem_we_o, stall_o, RegWrite_o, MemtoReg_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, ALUres_o, rddata_o;
    logic [4:0]  WriteBackPath_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .ALUres_i(ALUres_i), .wrdata_i(wrdata_i), .WriteBackPath_i(WriteBackPath_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
        .ALUres_o(ALUres_o), .rddata_o(rddata_o),
        .WriteBackPath_o(WriteBackPath_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_pend   = 1'b0;   // a transaction is outstanding
    int          m_waited = 0;      // BUSY cycles already spent without completion
    logic        m_req = 0, m_we = 0, m_rw = 0, m_mtr = 0, m_err = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_alu = '0, m_rd = '0;
    logic [4:0]  m_wbp = '0;

    function automatic bit timeout_now();
`ifdef MEM_TIMEOUT_EN
        return m_pend && !mem_ack_i && (m_waited + 1 == TMO);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit completes_now();
        return m_pend && (mem_ack_i || timeout_now());
    endfunction

    function automatic logic exp_stall();
        if (rst) return 1'b0;
        if (!m_pend) return MemRead_i | MemWrite_i;
        return !completes_now();
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 0; m_waited = 0; m_req = 0; m_we = 0; m_rw = 0; m_mtr = 0;
            m_err = 0; m_addr = '0; m_wdata = '0; m_alu = '0; m_rd = '0; m_wbp = '0;
        end else if (!m_pend) begin
            if (MemRead_i | MemWrite_i) begin
                m_pend = 1; m_waited = 0; m_req = 1; m_we = MemWrite_i;
                m_addr = ALUres_i; m_wdata = wrdata_i; m_rw = 0; m_mtr = 0;
            end else begin
                m_rw = RegWrite_i; m_mtr = MemtoReg_i; m_alu = ALUres_i;
                m_wbp = WriteBackPath_i; m_rd = 0;
            end
        end else if (completes_now()) begin
            if (!mem_ack_i) m_err = 1;
            m_rd  = m_we ? 32'd0 : (mem_ack_i ? mem_rdata_i : 32'hDEADBEEF);
            m_rw  = RegWrite_i; m_mtr = MemtoReg_i; m_alu = ALUres_i; m_wbp = WriteBackPath_i;
            m_pend = 0; m_req = 0;
        end else begin
            m_waited++; m_rw = 0; m_mtr = 0;
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        chk("stall_o",     {31'd0, stall_o},    {31'd0, exp_stall()});
        chk("mem_req_o",   {31'd0, mem_req_o},  {31'd0, m_req});
        chk("mem_we_o",    {31'd0, mem_we_o},   {31'd0, m_we});
        chk("mem_addr_o",  mem_addr_o,          m_addr);
        chk("mem_wdata_o", mem_wdata_o,         m_wdata);
        chk("RegWrite_o",  {31'd0, RegWrite_o}, {31'd0, m_rw});
        chk("MemtoReg_o",  {31'd0, MemtoReg_o}, {31'd0, m_mtr});
        chk("ALUres_o",    ALUres_o,            m_alu);
        chk("rddata_o",    rddata_o,            m_rd);
        chk("WBPath_o",    {27'd0, WriteBackPath_o}, {27'd0, m_wbp});
        chk("err_o",       {31'd0, err_o},      {31'd0, m_err});
    end

    // Length of the most recent mem_req_o low gap between two requests
    bit seen_req = 0;
    int gap = 0, last_gap = -1;
    always @(negedge clk) begin
        if (mem_req_o) begin
            if (seen_req && gap > 0) last_gap = gap;
            seen_req = 1; gap = 0;
        end else if (seen_req) begin
            gap++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic nop();
        MemRead_i = 0; MemWrite_i = 0; RegWrite_i = 0; MemtoReg_i = 0;
        mem_ack_i = 0; mem_rdata_i = '0;
    endtask

    // Present one memory instruction; ack on BUSY cycle ack_at (0 = never).
    task automatic run_mem(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] rdno,
                           input int ack_at, input logic [31:0] rdata, input int max_cyc,
                           output int stalls, output bit done);
        stalls = 0; done = 0;
        MemRead_i = rd; MemWrite_i = wr; RegWrite_i = rd & ~wr; MemtoReg_i = rd & ~wr;
        ALUres_i = addr; wrdata_i = data; WriteBackPath_i = rdno;
        for (int c = 0; c < max_cyc; c++) begin
            mem_ack_i   = (c >= 1) && (c == ack_at);
            mem_rdata_i = mem_ack_i ? rdata : 32'h0BAD_0BAD;
            #1;
            if (stall_o) stalls++;
            else if (c > 0) done = 1;
            step();
            if (done) break;
        end
        mem_ack_i = 0;
    endtask

    int  st;
    bit  dn;

    initial begin
        #1 rst = 1;
        step(); step();
        #1;
        chk("rst req",   {31'd0, mem_req_o},  32'd0);
        chk("rst stall", {31'd0, stall_o},    32'd0);
        chk("rst alu",   ALUres_o,            32'd0);
        rst = 0;
        step();

        // Non-memory instruction
        RegWrite_i = 1; ALUres_i = 32'h10; WriteBackPath_i = 5;
        #1 chk("add stall", {31'd0, stall_o}, 32'd0);
        step();
        chk("add alu", ALUres_o, 32'h10);
        chk("add rd",  {27'd0, WriteBackPath_o}, 32'd5);
        chk("add rw",  {31'd0, RegWrite_o}, 32'd1);
        nop();

        // ack in IDLE must be ignored
        mem_ack_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
        step(); nop(); step();

        // Load, ack on third BUSY cycle
        run_mem(1, 0, 32'h40, 32'h0, 5'd7, 3, 32'h1234_5678, 20, st, dn);
        chk("ld done",   {31'd0, dn}, 32'd1);
        chk("ld stalls", st, 32'd3);
        chk("ld rdata",  rddata_o, 32'h1234_5678);
        chk("ld m2r",    {31'd0, MemtoReg_o}, 32'd1);
        nop(); step();

        // Store, immediate ack; check port while requesting
        MemWrite_i = 1; ALUres_i = 32'h80; wrdata_i = 32'hCAFE_F00D;
        step();
        chk("st we",    {31'd0, mem_we_o}, 32'd1);
        chk("st addr",  mem_addr_o, 32'h80);
        chk("st wdata", mem_wdata_o, 32'hCAFE_F00D);
        mem_ack_i = 1;
        #1 chk("st ack stall", {31'd0, stall_o}, 32'd0);
        step(); nop();
        chk("st rw", {31'd0, RegWrite_o}, 32'd0);
        step();

        // Both read and write set: treated as store
        run_mem(1, 1, 32'h90, 32'h5555_AAAA, 5'd3, 2, 32'h7777_7777, 20, st, dn);
        chk("rw rdata", rddata_o, 32'd0);
        nop(); step();

        // Store then load back-to-back
        run_mem(0, 1, 32'h100, 32'h1111_2222, 5'd0, 1, 32'h0, 20, st, dn);
        run_mem(1, 0, 32'h100, 32'h0, 5'd9, 2, 32'hA5A5_0F0F, 20, st, dn);
        chk("b2b rdata", rddata_o, 32'hA5A5_0F0F);
        chk("b2b gap",   last_gap, 32'd1);
        nop(); step();

`ifdef MEM_TIMEOUT_EN
        run_mem(1, 0, 32'h200, 32'h0, 5'd4, 0, 32'h0, 20, st, dn);
        chk("tmo done",   {31'd0, dn}, 32'd1);
        chk("tmo stalls", st, TMO);
        chk("tmo rdata",  rddata_o, 32'hDEADBEEF);
        nop(); step(); step();
        chk("tmo err",    {31'd0, err_o}, 32'd1);
`else
        run_mem(1, 0, 32'h200, 32'h0, 5'd4, 0, 32'h0, 50, st, dn);
        chk("wait done",   {31'd0, dn}, 32'd0);
        chk("wait stalls", st, 32'd50);
        chk("wait err",    {31'd0, err_o}, 32'd0);
        mem_ack_i = 1; mem_rdata_i = 32'h0000_BEEF;
        #1 chk("late ack stall", {31'd0, stall_o}, 32'd0);
        step(); nop();
        chk("late rdata", rddata_o, 32'h0000_BEEF);
        step();
`endif

        // Asynchronous reset in the middle of a transaction
        run_mem(1, 0, 32'h300, 32'h0, 5'd12, 0, 32'h0, 2, st, dn);
        chk("pre-rst req", {31'd0, mem_req_o}, 32'd1);
        #2 rst = 1;
        #1;
        chk("arst req",   {31'd0, mem_req_o},  32'd0);
        chk("arst stall", {31'd0, stall_o},    32'd0);
        chk("arst rw",    {31'd0, RegWrite_o}, 32'd0);
        chk("arst alu",   ALUres_o,            32'd0);
        chk("arst rd",    {27'd0, WriteBackPath_o}, 32'd0);
        chk("arst err",   {31'd0, err_o},      32'd0);
        nop();
        step();
        rst = 0;
        step();
        RegWrite_i = 1; ALUres_i = 32'h55; WriteBackPath_i = 2;
        step(); nop();
        chk("post-rst alu", ALUres_o, 32'h55);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
